// File: rtl/move_pulse_gen_if.sv
// Button, game-state and move-pulse signals between the input conditioning
// stage (slave) and whatever drives the buttons and consumes the moves (master).
interface move_pulse_gen_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       game_over;
    logic       game_tick;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic [2:0] dir_q;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, game_over,
        input  game_tick, move_up, move_down, move_left, move_right, dir_q
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, game_over,
        output game_tick, move_up, move_down, move_left, move_right, dir_q
    );
endinterface

// File: rtl/move_pulse_gen.sv
// Synchronize/debounce four direction buttons, resolve one direction and emit
// one-cycle move pulses on the game tick. Optional macro: MOVE_LATCH_EN.
module move_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_CYCLES     = 8
) (
    input  logic             clk,
    input  logic             reset,
    move_pulse_gen_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // Bit order matches direction code minus one: up, down, left, right.
    logic [3:0] raw;
    logic [3:0] level;

    assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= ~level_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign level[gi] = level_reg;
        end
    endgenerate

    dir_t resolved;
    dir_t dir_reg;
    dir_t dir_next;

    always_comb begin
        resolved = DIR_NONE;
        if (level[0])      resolved = DIR_UP;
        else if (level[1]) resolved = DIR_DOWN;
        else if (level[2]) resolved = DIR_LEFT;
        else if (level[3]) resolved = DIR_RIGHT;
    end

    always_comb begin
        dir_next = dir_reg;
`ifdef MOVE_LATCH_EN
        // Held direction persists after release; game over drops it entirely.
        if (bus.game_over)
            dir_next = DIR_NONE;
        else if (resolved != DIR_NONE)
            dir_next = resolved;
`else
        dir_next = resolved;
`endif
    end

    logic [TW-1:0] tick_cnt_reg;
    logic          tick_wrap;
    logic          game_tick_reg;
    logic [3:0]    move_reg;
    logic [3:0]    move_next;

    assign tick_wrap = (tick_cnt_reg == TICK_LAST);

    // Pulses use dir_reg before this edge, so a same-edge direction change waits a tick.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_move
            assign move_next[gi] = tick_wrap && !bus.game_over && (dir_reg == dir_t'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg  <= '0;
            game_tick_reg <= 1'b0;
            move_reg      <= '0;
            dir_reg       <= DIR_NONE;
        end else begin
            tick_cnt_reg  <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
            game_tick_reg <= tick_wrap;
            move_reg      <= move_next;
            dir_reg       <= dir_next;
        end
    end

    assign bus.game_tick  = game_tick_reg;
    assign bus.move_up    = move_reg[0];
    assign bus.move_down  = move_reg[1];
    assign bus.move_left  = move_reg[2];
    assign bus.move_right = move_reg[3];
    assign bus.dir_q      = dir_reg;

endmodule

// File: tb/tb_move_pulse_gen.sv
// Directed bench for move_pulse_gen (DEBOUNCE_CYCLES=4, TICK_CYCLES=8); expected
// direction changes are scheduled by hand, pulses follow from tick timing.
module tb_move_pulse_gen;

`ifdef MOVE_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    move_pulse_gen_if bus ();

    move_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         passed = 0;
    int         failed = 0;
    int         total  = 0;
    int         cyc    = 0;
    logic [2:0] cur_dir = 3'd0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tick"}, {7'd0, bus.game_tick}, 8'd0);
        chk({tag, "_move"}, {4'd0, bus.move_right, bus.move_left, bus.move_down, bus.move_up}, 8'd0);
        chk({tag, "_dir"},  {5'd0, bus.dir_q}, 8'd0);
    endtask

    // Advance one clock; dir_after is the hand-derived dir_q once this edge lands.
    task automatic tick_to(input logic [2:0] dir_after);
        logic [2:0] d_b;
        logic       go_b;
        logic       exp_tk;
        logic [3:0] exp_mv;
        d_b  = cur_dir;
        go_b = bus.game_over;
        @(posedge clk);
        #1;
        cyc++;
        exp_tk = (cyc % 8 == 0);
        exp_mv = 4'd0;
        if (exp_tk && !go_b && d_b != 3'd0) exp_mv[d_b - 3'd1] = 1'b1;
        cur_dir = dir_after;
        chk("tick", {7'd0, bus.game_tick}, {7'd0, exp_tk});
        chk("move", {4'd0, bus.move_right, bus.move_left, bus.move_down, bus.move_up}, {4'd0, exp_mv});
        chk("dir",  {5'd0, bus.dir_q}, {5'd0, dir_after});
        $display("cyc=%0d tick=%0b move(r,l,d,u)=%b dir=%0d", cyc, bus.game_tick,
                 {bus.move_right, bus.move_left, bus.move_down, bus.move_up}, bus.dir_q);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick_to(cur_dir);
    endtask

    initial begin
        reset         = 1'b1;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.game_over = 1'b0;

        // 1: reset state, then idle ticks at 8,16,24,32,40
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        cyc   = 0;
        hold(40);

        // 2: bouncing right button, then a clean press
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) bus.btn_right = ~bus.btn_right;
            tick_to(3'd0);
        end
        bus.btn_right = 1'b1;
        hold(6);
        tick_to(3'd4);
        hold(24);

        // 3: up and left together, up wins
        bus.btn_right = 1'b0;
        bus.btn_up    = 1'b1;
        bus.btn_left  = 1'b1;
        hold(6);
        tick_to(3'd1);
        hold(20);

        // 4: left alone, then released
        bus.btn_up = 1'b0;
        hold(6);
        tick_to(3'd3);
        hold(17);
        bus.btn_left = 1'b0;
        hold(6);
        tick_to(LATCH ? 3'd3 : 3'd0);
        hold(24);

        // 5: right held, then game over for 3 ticks starting the cycle before a tick
        bus.btn_right = 1'b1;
        hold(6);
        tick_to(3'd4);
        hold(10);
        for (int k = 0; k < 8 && (cyc % 8) != 7; k++) tick_to(cur_dir);
        bus.game_over = 1'b1;
        if (LATCH) bus.btn_right = 1'b0;
        tick_to(LATCH ? 3'd0 : 3'd4);
        hold(23);
        bus.game_over = 1'b0;
        hold(24);

        // 6: reset mid-debounce and mid-tick with a live direction
        bus.btn_right = 1'b0;
        bus.btn_down  = 1'b1;
        hold(6);
        tick_to(3'd2);
        hold(4);
        for (int k = 0; k < 8 && (cyc % 8) != 2; k++) tick_to(cur_dir);
        bus.btn_up = 1'b1;
        hold(3);
        chk("pre_reset_dir", {5'd0, bus.dir_q}, 8'd2);
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_idle("in_reset");
        end
        reset   = 1'b0;
        cyc     = 0;
        cur_dir = 3'd0;
        hold(6);
        tick_to(3'd1);
        hold(12);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        hold(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
